// File: rtl/compare_scheduler_if.sv
// Request/grant/result bundle between two ALU-side requesters and compare_scheduler.
// Optional COMPARE_PARITY_EN adds the ep (even parity of S) result line.
interface compare_scheduler_if #(
  parameter int unsigned WIDTH = 4
);
  logic             req0;
  logic [WIDTH-1:0] x0;
  logic [WIDTH-1:0] y0;
  logic             req1;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] y1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic             v;
  logic             n;
  logic             z;
`ifdef COMPARE_PARITY_EN
  logic             ep;
`endif

  modport master (
    output req0, x0, y0, req1, x1, y1,
`ifdef COMPARE_PARITY_EN
    input  ep,
`endif
    input  gnt0, gnt1, busy, done, done_id, v, n, z
  );

  modport slave (
    input  req0, x0, y0, req1, x1, y1,
`ifdef COMPARE_PARITY_EN
    output ep,
`endif
    output gnt0, gnt1, busy, done, done_id, v, n, z
  );
endinterface

// File: rtl/compare_scheduler.sv
// Round-robin shared bit-serial compare engine (S = x - y, LSB first) returning v/n/z.
// Define COMPARE_PARITY_EN to add the registered even-parity flag ep.
module compare_scheduler #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  compare_scheduler_if.slave   bus
);
  localparam int unsigned IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q;
  logic             last_gnt_q;
  logic             id_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] s_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             busy_q;
  logic             done_q;
  logic             done_id_q;
  logic             v_q;
  logic             n_q;
  logic             z_q;
`ifdef COMPARE_PARITY_EN
  logic             ep_q;
`endif

  logic             slice_s;
  logic             slice_c;
  logic             last_bit;
  logic [WIDTH-1:0] s_d;

  // One full-adder slice: x[i] + ~y[i] + carry; s_d is S with the current bit merged in.
  always_comb begin
    {slice_c, slice_s} = {1'b0, x_q[idx_q]} + {1'b0, ~y_q[idx_q]} + {1'b0, carry_q};
    s_d                = s_q;
    s_d[idx_q]         = slice_s;
    last_bit           = (idx_q == IW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      id_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      s_q        <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= 1'b0;
      v_q        <= 1'b0;
      n_q        <= 1'b0;
      z_q        <= 1'b0;
`ifdef COMPARE_PARITY_EN
      ep_q       <= 1'b0;
`endif
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // On a tie, requester 0 wins only if requester 1 was served last.
          if (bus.req0 && (!bus.req1 || last_gnt_q)) begin
            x_q        <= bus.x0;
            y_q        <= bus.y0;
            id_q       <= 1'b0;
            last_gnt_q <= 1'b0;
            gnt0_q     <= 1'b1;
            s_q        <= '0;
            carry_q    <= 1'b1;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end else if (bus.req1) begin
            x_q        <= bus.x1;
            y_q        <= bus.y1;
            id_q       <= 1'b1;
            last_gnt_q <= 1'b1;
            gnt1_q     <= 1'b1;
            s_q        <= '0;
            carry_q    <= 1'b1;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          s_q     <= s_d;
          carry_q <= slice_c;
          idx_q   <= idx_q + IW'(1);
          if (last_bit) begin
            // carry_q here is the carry into the MSB slice, slice_c the carry out.
            v_q       <= slice_c ^ carry_q;
            n_q       <= s_d[WIDTH-1];
            z_q       <= (s_d == '0);
`ifdef COMPARE_PARITY_EN
            ep_q      <= ^s_d;
`endif
            done_id_q <= id_q;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.v       = v_q;
  assign bus.n       = n_q;
  assign bus.z       = z_q;
`ifdef COMPARE_PARITY_EN
  assign bus.ep      = ep_q;
`endif
endmodule

// File: tb/tb_compare_scheduler.sv
// Directed bench for compare_scheduler (WIDTH=4): flags, latency, arbitration, reset abort.
module tb_compare_scheduler;
  localparam int unsigned WIDTH = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  compare_scheduler_if #(.WIDTH(WIDTH)) bus ();

  compare_scheduler #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n    = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.x0   = '0;
    bus.y0   = '0;
    bus.x1   = '0;
    bus.y1   = '0;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.done_id, bus.v, bus.n, bus.z} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.done_id, bus.v, bus.n, bus.z});
    end
`ifdef COMPARE_PARITY_EN
    checks++;
    if (bus.ep !== 1'b0) begin
      errors++;
      $display("FAIL reset_ep: got %b expected 0", bus.ep);
    end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Single-requester compares; expected S/flags worked out by hand for WIDTH=4.
  task automatic test_vectors();
    logic       vreq [5];
    logic [3:0] vx   [5];
    logic [3:0] vy   [5];
    logic [2:0] vvnz [5];
    logic       vep  [5];
    int         t;
    logic       seen;
    vreq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vx   = '{4'd5, 4'd3, 4'd7, 4'b0111, 4'b1000};
    vy   = '{4'd3, 4'd5, 4'd7, 4'b1000, 4'b0001};
    // S: 0010, 1110, 0000, 1111, 0111
    vvnz = '{3'b000, 3'b010, 3'b001, 3'b110, 3'b100};
    vep  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      if (vreq[i]) begin
        bus.req1 = 1'b1; bus.x1 = vx[i]; bus.y1 = vy[i];
      end else begin
        bus.req0 = 1'b1; bus.x0 = vx[i]; bus.y0 = vy[i];
      end
      seen = 1'b0;
      for (t = 1; t <= 4; t++) begin
        @(negedge clk);
        if ((vreq[i] ? bus.gnt1 : bus.gnt0) === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      checks++;
      if (!seen || t != 1) begin
        errors++;
        $display("FAIL vec%0d_gnt_latency: got %0d cycles (seen=%b) expected 1", i, t, seen);
      end
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL vec%0d_busy: got %b expected 1", i, bus.busy);
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      seen = 1'b0;
      for (t = 1; t <= WIDTH + 3; t++) begin
        @(negedge clk);
        if (bus.done === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      checks++;
      if (!seen || t != WIDTH) begin
        errors++;
        $display("FAIL vec%0d_done_latency: got %0d cycles after gnt (seen=%b) expected %0d",
                 i, t, seen, WIDTH);
      end
      checks++;
      if (bus.done_id !== vreq[i] || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_done_id_busy: got id=%b busy=%b expected id=%b busy=0",
                 i, bus.done_id, bus.busy, vreq[i]);
      end
      checks++;
      if ({bus.v, bus.n, bus.z} !== vvnz[i]) begin
        errors++;
        $display("FAIL vec%0d_vnz: got %b expected %b", i, {bus.v, bus.n, bus.z}, vvnz[i]);
      end
`ifdef COMPARE_PARITY_EN
      checks++;
      if (bus.ep !== vep[i]) begin
        errors++;
        $display("FAIL vec%0d_ep: got %b expected %b", i, bus.ep, vep[i]);
      end
`endif
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || {bus.v, bus.n, bus.z} !== vvnz[i] || bus.done_id !== vreq[i]) begin
        errors++;
        $display("FAIL vec%0d_hold: got done=%b vnz=%b id=%b expected done=0 vnz=%b id=%b",
                 i, bus.done, {bus.v, bus.n, bus.z}, bus.done_id, vvnz[i], vreq[i]);
      end
    end
    if (vep[0] === 1'bx) $display("unreachable");
  endtask

  // Two simultaneous held requests after reset; repeated to confirm last_gnt rotation.
  task automatic test_back_to_back();
    int   t;
    logic seen;
    test_reset();
    for (int r = 0; r < 2; r++) begin
      bus.req0 = 1'b1; bus.x0 = 4'd5; bus.y0 = 4'd3;
      bus.req1 = 1'b1; bus.x1 = 4'd3; bus.y1 = 4'd5;
      @(negedge clk);
      checks++;
      if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
        errors++;
        $display("FAIL b2b%0d_first_gnt: got gnt0=%b gnt1=%b expected gnt0=1 gnt1=0",
                 r, bus.gnt0, bus.gnt1);
      end
      bus.req0 = 1'b0;
      seen = 1'b0;
      for (t = 1; t <= WIDTH + 3; t++) begin
        @(negedge clk);
        if (bus.done === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      checks++;
      if (!seen || bus.done_id !== 1'b0 || {bus.v, bus.n, bus.z} !== 3'b000) begin
        errors++;
        $display("FAIL b2b%0d_first_done: got seen=%b id=%b vnz=%b expected seen=1 id=0 vnz=000",
                 r, seen, bus.done_id, {bus.v, bus.n, bus.z});
      end
      @(negedge clk);
      checks++;
      if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin
        errors++;
        $display("FAIL b2b%0d_second_gnt: got gnt0=%b gnt1=%b expected gnt0=0 gnt1=1",
                 r, bus.gnt0, bus.gnt1);
      end
      bus.req1 = 1'b0;
      seen = 1'b0;
      for (t = 1; t <= WIDTH + 3; t++) begin
        @(negedge clk);
        if (bus.done === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      checks++;
      if (!seen || bus.done_id !== 1'b1 || {bus.v, bus.n, bus.z} !== 3'b010) begin
        errors++;
        $display("FAIL b2b%0d_second_done: got seen=%b id=%b vnz=%b expected seen=1 id=1 vnz=010",
                 r, seen, bus.done_id, {bus.v, bus.n, bus.z});
      end
      @(negedge clk);
    end
  endtask

  // Abort a 7-(-8) compare at i=2 after a completion left v=1/n=1 set.
  task automatic test_reset_mid_run();
    int   t;
    logic seen;
    logic stray;
    bus.req0 = 1'b1; bus.x0 = 4'b0111; bus.y0 = 4'b1000;
    seen = 1'b0;
    for (t = 1; t <= WIDTH + 3; t++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.gnt0 === 1'b1) bus.req0 = 1'b0;
    end
    bus.req0 = 1'b0;
    checks++;
    if (!seen || {bus.v, bus.n, bus.z} !== 3'b110) begin
      errors++;
      $display("FAIL rst_pre_compare: got seen=%b vnz=%b expected seen=1 vnz=110",
               seen, {bus.v, bus.n, bus.z});
    end
    @(negedge clk);
    bus.req0 = 1'b1; bus.x0 = 4'b0111; bus.y0 = 4'b1000;
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_run_gnt: got %b expected 1", bus.gnt0);
    end
    bus.req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.done_id, bus.v, bus.n, bus.z} !== 8'b0) begin
      errors++;
      $display("FAIL rst_midrun_outputs: got %b expected 00000000",
               {bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.done_id, bus.v, bus.n, bus.z});
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_done: got activity=%b expected 0", stray);
    end
    bus.req0 = 1'b1; bus.x0 = 4'd5; bus.y0 = 4'd3;
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_after_gnt: got %b expected 1", bus.gnt0);
    end
    bus.req0 = 1'b0;
    seen = 1'b0;
    for (t = 1; t <= WIDTH + 3; t++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || t != WIDTH || bus.done_id !== 1'b0 || {bus.v, bus.n, bus.z} !== 3'b000) begin
      errors++;
      $display("FAIL rst_after_done: got seen=%b t=%0d id=%b vnz=%b expected seen=1 t=%0d id=0 vnz=000",
               seen, t, bus.done_id, {bus.v, bus.n, bus.z}, WIDTH);
    end
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
